// File: rtl/digit_scan_ctrl_pkg.sv
// Shared select codes and state encodings for the digit scanner and the digit mux.
// The anode decode lives here so both sides agree on the digit-to-anode mapping.
package digit_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      SEL_NULL = 2'b00,
      SEL_SEC  = 2'b01,
      SEL_TEN  = 2'b10,
      SEL_MIN  = 2'b11
   } sel_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHOW  = 2'b01,
      ST_BLANK = 2'b10
   } state_e;

   // Active-low anodes; NULL (and anything else) leaves every digit dark.
   function automatic logic [2:0] an_decode(input sel_e sel);
      logic [2:0] an;
      an = 3'b111;
      case (sel)
         SEL_SEC: an = 3'b110;
         SEL_TEN: an = 3'b101;
         SEL_MIN: an = 3'b011;
         default: an = 3'b111;
      endcase
      return an;
   endfunction

   function automatic sel_e next_idx(input sel_e idx);
      sel_e nxt;
      case (idx)
         SEL_SEC: nxt = SEL_TEN;
         SEL_TEN: nxt = SEL_MIN;
         default: nxt = SEL_SEC;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/digit_scan_ctrl_prescaler.sv
// Phase counter for the digit scanner: counts up to a run-time terminal value,
// wraps to zero on terminal count and clears synchronously on demand.
module scan_prescaler #(
   parameter int CNT_W = 10
) (
   input  logic             clk_mux,
   input  logic             rst_mux,
   input  logic             clr_in,
   input  logic [CNT_W-1:0] term_in,
   output logic             tc_out
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tc_out = (cnt_q == term_in);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_in || tc_out) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_mux or posedge rst_mux) begin
      if (rst_mux) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Three-digit multiplexed display scanner: SHOW/BLANK slot sequencing, registered
// digit select, anode enables one cycle behind select, and frame tick.
module digit_scan_ctrl
   import digit_scan_ctrl_pkg::*;
#(
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic       clk_mux,
   input  logic       rst_mux,
   input  logic       scan_en_in,
   input  logic       lz_en_in,
   input  logic [3:0] min_digit_in,
   output logic [1:0] sel_out,
   output logic [2:0] an_out,
   output logic       frame_tick_out
);

   localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   state_e           state_q, state_d;
   sel_e             idx_q, idx_d;
   sel_e             sel_q, sel_d;
   logic [2:0]       an_q, an_d;
   logic             tick_q, tick_d;
   logic             sup_q, sup_d;
   logic             cnt_clr;
   logic             cnt_tc;
   logic [CNT_W-1:0] cnt_term;

   assign cnt_clr  = !scan_en_in || (state_q == ST_IDLE);
   assign cnt_term = (state_q == ST_BLANK) ? CNT_W'(BLANK_CYC - 1) : CNT_W'(SCAN_DIV - 1);

   scan_prescaler #(
      .CNT_W (CNT_W)
   ) u_prescaler (
      .clk_mux (clk_mux),
      .rst_mux (rst_mux),
      .clr_in  (cnt_clr),
      .term_in (cnt_term),
      .tc_out  (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tick_d  = 1'b0;
      sup_d   = sup_q;
      if (!scan_en_in) begin
         state_d = ST_IDLE;
         idx_d   = SEL_SEC;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SHOW;
               idx_d   = SEL_SEC;
            end
            ST_SHOW: begin
               if (cnt_tc) state_d = ST_BLANK;
            end
            ST_BLANK: begin
               if (cnt_tc) begin
                  state_d = ST_SHOW;
                  idx_d   = next_idx(idx_q);
                  tick_d  = (idx_q == SEL_MIN);
                  // Blanking decision is frozen at MIN slot entry so the slot is all-or-nothing.
                  if (idx_q == SEL_TEN) sup_d = lz_en_in && (min_digit_in == 4'd0);
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = SEL_SEC;
            end
         endcase
      end

      sel_d = (state_d == ST_SHOW) ? idx_d : SEL_NULL;

      // Anodes follow the select one cycle later, matching the registered digit mux.
      an_d = an_decode(sel_q);
      if (sup_q) an_d[2] = 1'b1;
   end

   always_ff @(posedge clk_mux or posedge rst_mux) begin
      if (rst_mux) begin
         state_q <= ST_IDLE;
         idx_q   <= SEL_SEC;
         sel_q   <= SEL_NULL;
         an_q    <= 3'b111;
         tick_q  <= 1'b0;
         sup_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         an_q    <= an_d;
         tick_q  <= tick_d;
         sup_q   <= sup_d;
      end
   end

   assign sel_out        = sel_q;
   assign an_out         = an_q;
   assign frame_tick_out = tick_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with SCAN_DIV=4, BLANK_CYC=2 (18-cycle frame).
module tb_digit_scan_ctrl;

   logic       clk_mux;
   logic       rst_mux;
   logic       scan_en_in;
   logic       lz_en_in;
   logic [3:0] min_digit_in;
   logic [1:0] sel_out;
   logic [2:0] an_out;
   logic       frame_tick_out;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       en;
      logic       lz;
      logic [3:0] mind;
      logic [1:0] sel;
      logic [2:0] an;
      logic       tick;
   } vec_t;

   vec_t vecs[40];

   digit_scan_ctrl #(
      .SCAN_DIV  (4),
      .BLANK_CYC (2)
   ) dut (
      .clk_mux        (clk_mux),
      .rst_mux        (rst_mux),
      .scan_en_in     (scan_en_in),
      .lz_en_in       (lz_en_in),
      .min_digit_in   (min_digit_in),
      .sel_out        (sel_out),
      .an_out         (an_out),
      .frame_tick_out (frame_tick_out)
   );

   initial clk_mux = 1'b0;
   always #5 clk_mux = ~clk_mux;

   function automatic logic [2:0] exp_an(input logic [1:0] s);
      case (s)
         2'b01:   return 3'b110;
         2'b10:   return 3'b101;
         2'b11:   return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_onehot();
      int zeros;
      zeros = 0;
      for (int b = 0; b < 3; b++) if (an_out[b] === 1'b0) zeros++;
      checks++;
      if (zeros > 1 || $isunknown(an_out)) begin
         failures++;
         $display("FAIL an_onehot actual=%b required=at_most_one_zero at %0t", an_out, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_mux);
      #1;
      chk_onehot();
   endtask

   initial begin : main
      logic [1:0] sel_pat [18];
      sel_pat = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0,
                  2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0,
                  2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
      for (int p = 0; p < 40; p++) begin
         vecs[p].en   = 1'b1;
         vecs[p].lz   = 1'b0;
         vecs[p].mind = 4'd0;
         vecs[p].sel  = sel_pat[p % 18];
         vecs[p].an   = (p == 0) ? 3'b111 : exp_an(sel_pat[(p - 1) % 18]);
         vecs[p].tick = (p > 0) && (p % 18 == 0);
      end

      // Reset state
      rst_mux      = 1'b1;
      scan_en_in   = 1'b0;
      lz_en_in     = 1'b0;
      min_digit_in = 4'd0;
      step();
      step();
      chk("rst_sel", sel_out, 2'b00);
      chk("rst_an", an_out, 3'b111);
      chk("rst_tick", frame_tick_out, 1'b0);
      @(negedge clk_mux);
      rst_mux = 1'b0;

      // Tests 1/2: scan pattern, shifted anodes and frame tick
      for (int i = 0; i < 40; i++) begin
         scan_en_in   = vecs[i].en;
         lz_en_in     = vecs[i].lz;
         min_digit_in = vecs[i].mind;
         step();
         chk($sformatf("t1_sel[%0d]", i), sel_out, vecs[i].sel);
         chk($sformatf("t1_an[%0d]", i), an_out, vecs[i].an);
         chk($sformatf("t2_tick[%0d]", i), frame_tick_out, vecs[i].tick);
      end
      scan_en_in = 1'b0;
      step();
      step();
      chk("idle_an", an_out, 3'b111);

      // Test 3: leading-zero suppression, frozen at MIN slot entry
      lz_en_in     = 1'b1;
      min_digit_in = 4'd0;
      scan_en_in   = 1'b1;
      for (int p = 0; p < 36; p++) begin
         step();
         if (p < 18) chk($sformatf("t3_an2_dark[%0d]", p), an_out[2], 1'b1);
         if (p >= 13 && p <= 16) chk($sformatf("t3_an_dark[%0d]", p), an_out, 3'b111);
         if (p == 12) chk("t3_sel_min", sel_out, 2'b11);
         if (p >= 31 && p <= 34) chk($sformatf("t3_an_lit[%0d]", p), an_out, 3'b011);
         if (p == 13) min_digit_in = 4'd5;
      end
      scan_en_in = 1'b0;
      lz_en_in   = 1'b0;
      step();
      step();

      // Test 4: disable on the last SHOW-TEN_SEC cycle
      scan_en_in = 1'b1;
      for (int p = 0; p < 10; p++) step();
      chk("t4_sel_ten", sel_out, 2'b10);
      scan_en_in = 1'b0;
      step();
      chk("t4_sel_off", sel_out, 2'b00);
      chk("t4_no_tick", frame_tick_out, 1'b0);
      chk("t4_an_lag", an_out, 3'b101);
      step();
      chk("t4_an_off", an_out, 3'b111);
      scan_en_in = 1'b1;
      for (int p = 0; p < 4; p++) begin
         step();
         chk($sformatf("t4_restart_sel[%0d]", p), sel_out, 2'b01);
      end
      step();
      chk("t4_restart_blank", sel_out, 2'b00);

      // Test 5: asynchronous reset in the middle of the MIN slot
      for (int k = 0; k < 20 && sel_out !== 2'b11; k++) step();
      chk("t5_reach_min", sel_out, 2'b11);
      step();
      chk("t5_an_min", an_out, 3'b011);
      #2;
      rst_mux = 1'b1;
      #1;
      chk("t5_async_sel", sel_out, 2'b00);
      chk("t5_async_an", an_out, 3'b111);
      chk("t5_async_tick", frame_tick_out, 1'b0);
      chk_onehot();
      step();
      chk("t5_hold_sel", sel_out, 2'b00);
      chk("t5_hold_an", an_out, 3'b111);
      rst_mux = 1'b0;
      step();
      chk("t5_restart_sel", sel_out, 2'b01);
      chk("t5_restart_an", an_out, 3'b111);
      step();
      chk("t5_restart_an2", an_out, 3'b110);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
